// File: rtl/counter_bank.sv
// counter_bank: NUM_CH independent WIDTH-bit counters, each with an IDLE/RUN/DONE FSM,
// programmable terminal value, wrap/saturate mode, load and sticky overflow. Define COUNTER_DOWN_EN for down counting.
module counter_bank #(
  parameter int WIDTH  = 4,
  parameter int NUM_CH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       start_i,
  input  logic [NUM_CH-1:0]       stop_i,
  input  logic [NUM_CH-1:0]       en_i,
  input  logic [NUM_CH-1:0]       load_i,
  input  logic [NUM_CH*WIDTH-1:0] cnt_i,
  input  logic [NUM_CH*WIDTH-1:0] limit_i,
  input  logic [NUM_CH-1:0]       sat_i,
  input  logic [NUM_CH-1:0]       dir_i,
  input  logic [NUM_CH-1:0]       clear_i,
  output logic [NUM_CH*WIDTH-1:0] cnt_o,
  output logic [NUM_CH-1:0]       busy_o,
  output logic [NUM_CH-1:0]       done_o,
  output logic [NUM_CH-1:0]       tc_o,
  output logic [NUM_CH-1:0]       ovf_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

`ifndef COUNTER_DOWN_EN
  logic unused_dir;
  assign unused_dir = ^dir_i;
`endif

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] limit, load_val, restart;
    logic             down, at_term, ovf_set;

    assign limit    = limit_i[k*WIDTH +: WIDTH];
    assign load_val = cnt_i[k*WIDTH +: WIDTH];

`ifdef COUNTER_DOWN_EN
    assign down    = dir_i[k];
    assign restart = down ? limit : '0;
    assign at_term = down ? (cnt_q == '0) : (cnt_q == limit);
`else
    assign down    = 1'b0;
    assign restart = '0;
    assign at_term = (cnt_q == limit);
`endif

    // Stop beats everything, then load, then start/count; load leaves the state alone.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tc_d    = 1'b0;
      ovf_set = 1'b0;
      if (stop_i[k]) begin
        state_d = ST_IDLE;
      end else if (load_i[k]) begin
        cnt_d = load_val;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE: begin
            if (start_i[k]) begin
              state_d = ST_RUN;
              cnt_d   = restart;
            end
          end
          ST_RUN: begin
            if (en_i[k]) begin
              if (at_term) begin
                tc_d = 1'b1;
                if (sat_i[k]) begin
                  state_d = ST_DONE;
                end else begin
                  cnt_d   = restart;
                  ovf_set = 1'b1;
                end
              end else if (down) begin
                cnt_d = cnt_q - ONE;
              end else begin
                // Natural rollover past all-ones only happens after a load above the limit.
                cnt_d   = cnt_q + ONE;
                ovf_set = &cnt_q;
              end
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
      ovf_d = ovf_set | (ovf_q & ~clear_i[k]);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        tc_q    <= 1'b0;
        ovf_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        tc_q    <= tc_d;
        ovf_q   <= ovf_d;
      end
    end

    assign cnt_o[k*WIDTH +: WIDTH] = cnt_q;
    assign busy_o[k] = (state_q == ST_RUN);
    assign done_o[k] = (state_q == ST_DONE);
    assign tc_o[k]   = tc_q;
    assign ovf_o[k]  = ovf_q;
  end

endmodule

// File: tb/tb_counter_bank.sv
// Bench for counter_bank: directed scenarios plus random traffic, checked every cycle
// against a behavioural model through an expected-output queue.
module tb_counter_bank;
  localparam int WIDTH  = 4;
  localparam int NUM_CH = 2;
  localparam int CW     = NUM_CH * WIDTH;
  localparam int OUT_W  = CW + 4 * NUM_CH;
  localparam int MOD    = 1 << WIDTH;

  logic              clk, rst;
  logic [NUM_CH-1:0] start_i, stop_i, en_i, load_i, sat_i, dir_i, clear_i;
  logic [CW-1:0]     cnt_i, limit_i;
  logic [CW-1:0]     cnt_o;
  logic [NUM_CH-1:0] busy_o, done_o, tc_o, ovf_o;

  counter_bank #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) dut (
    .clk(clk), .rst(rst),
    .start_i(start_i), .stop_i(stop_i), .en_i(en_i), .load_i(load_i),
    .cnt_i(cnt_i), .limit_i(limit_i), .sat_i(sat_i), .dir_i(dir_i), .clear_i(clear_i),
    .cnt_o(cnt_o), .busy_o(busy_o), .done_o(done_o), .tc_o(tc_o), .ovf_o(ovf_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // reference model: 0 = idle, 1 = run, 2 = done
  int m_state [NUM_CH];
  int m_cnt   [NUM_CH];
  bit m_tc    [NUM_CH];
  bit m_ovf   [NUM_CH];

  logic [OUT_W-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  task automatic model_step();
    for (int k = 0; k < NUM_CH; k++) begin
      int lim;
      bit down;
      bit set;
      lim = int'(limit_i[k*WIDTH +: WIDTH]);
`ifdef COUNTER_DOWN_EN
      down = dir_i[k];
`else
      down = 1'b0;
`endif
      set = 1'b0;
      m_tc[k] = 1'b0;
      if (rst) begin
        m_state[k] = 0;
        m_cnt[k]   = 0;
        m_ovf[k]   = 1'b0;
      end else begin
        if (stop_i[k]) begin
          m_state[k] = 0;
        end else if (load_i[k]) begin
          m_cnt[k] = int'(cnt_i[k*WIDTH +: WIDTH]);
        end else if (m_state[k] != 1 && start_i[k]) begin
          m_state[k] = 1;
          m_cnt[k]   = down ? lim : 0;
        end else if (m_state[k] == 1 && en_i[k]) begin
          if ((down && m_cnt[k] == 0) || (!down && m_cnt[k] == lim)) begin
            m_tc[k] = 1'b1;
            if (sat_i[k]) m_state[k] = 2;
            else begin
              m_cnt[k] = down ? lim : 0;
              set = 1'b1;
            end
          end else if (down) begin
            m_cnt[k] = m_cnt[k] - 1;
          end else begin
            m_cnt[k] = m_cnt[k] + 1;
            if (m_cnt[k] == MOD) begin
              m_cnt[k] = 0;
              set = 1'b1;
            end
          end
        end
        m_ovf[k] = set || (m_ovf[k] && !clear_i[k]);
      end
    end
  endtask

  function automatic logic [OUT_W-1:0] model_pack();
    logic [CW-1:0]     c;
    logic [NUM_CH-1:0] b, d, t, o;
    for (int k = 0; k < NUM_CH; k++) begin
      c[k*WIDTH +: WIDTH] = WIDTH'(m_cnt[k]);
      b[k] = (m_state[k] == 1);
      d[k] = (m_state[k] == 2);
      t[k] = m_tc[k];
      o[k] = m_ovf[k];
    end
    return {c, b, d, t, o};
  endfunction

  // driver tasks
  task automatic tick();
    model_step();
    exp_q.push_back(model_pack());
    @(negedge clk);
    cycle++;
  endtask

  task automatic set_lim(input int k, input int v);
    limit_i[k*WIDTH +: WIDTH] = WIDTH'(v);
  endtask

  task automatic set_cnt(input int k, input int v);
    cnt_i[k*WIDTH +: WIDTH] = WIDTH'(v);
  endtask

  task automatic clr_strobes();
    start_i = '0;
    stop_i  = '0;
    load_i  = '0;
    clear_i = '0;
  endtask

  function automatic logic [NUM_CH-1:0] rbits(input int unsigned n);
    logic [NUM_CH-1:0] r;
    for (int k = 0; k < NUM_CH; k++) r[k] = ($urandom_range(n - 1, 0) == 0);
    return r;
  endfunction

  // scoreboard monitor
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        logic [OUT_W-1:0] e;
        logic [OUT_W-1:0] a;
        e = exp_q.pop_front();
        a = {cnt_o, busy_o, done_o, tc_o, ovf_o};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs @cycle %0d: got cnt=%h busy=%b done=%b tc=%b ovf=%b, exp cnt=%h busy=%b done=%b tc=%b ovf=%b",
                   cycle, a[OUT_W-1 -: CW], a[4*NUM_CH-1 -: NUM_CH], a[3*NUM_CH-1 -: NUM_CH],
                   a[2*NUM_CH-1 -: NUM_CH], a[NUM_CH-1:0],
                   e[OUT_W-1 -: CW], e[4*NUM_CH-1 -: NUM_CH], e[3*NUM_CH-1 -: NUM_CH],
                   e[2*NUM_CH-1 -: NUM_CH], e[NUM_CH-1:0]);
        end
      end
    end
  end

  // stimulus
  initial begin
    rst = 1'b1;
    clr_strobes();
    en_i = '0; sat_i = '0; dir_i = '0; cnt_i = '0; limit_i = '0;
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;

    // wrap at limit 5
    set_lim(0, 5);
    start_i = 2'b01; tick(); start_i = '0;
    en_i = 2'b01; repeat (8) tick();

    // saturate at limit 3, then restart from DONE
    en_i = '0; stop_i = 2'b01; tick(); stop_i = '0;
    set_lim(0, 3); sat_i = 2'b01;
    start_i = 2'b01; tick(); start_i = '0;
    en_i = 2'b01; repeat (6) tick();
    en_i = '0; start_i = 2'b01; tick(); start_i = '0; tick();

    // load above limit: natural rollover then terminal wrap
    sat_i = '0; set_lim(0, 5); clear_i = 2'b01; tick(); clear_i = '0;
    set_cnt(0, 14); load_i = 2'b01; tick(); load_i = '0;
    en_i = 2'b01; repeat (10) tick();

    // same-cycle conflicts
    en_i = '0; stop_i = 2'b01; tick();
    start_i = 2'b01; tick(); clr_strobes(); tick();
    start_i = 2'b01; tick(); start_i = '0;
    set_cnt(0, 9); load_i = 2'b01; en_i = 2'b01; tick(); load_i = '0;
    set_lim(0, 0); clear_i = 2'b01; repeat (3) tick();
    en_i = '0; set_lim(0, 15); tick(); clear_i = '0; tick();

    // down counting (counts up when the feature is absent)
    stop_i = 2'b01; tick(); stop_i = '0;
    dir_i = 2'b01; set_lim(0, 4);
    start_i = 2'b01; tick(); start_i = '0;
    en_i = 2'b01; repeat (6) tick();

    // two channels concurrently, reset mid-run
    en_i = '0; dir_i = '0; stop_i = 2'b11; tick(); stop_i = '0;
    set_lim(0, 3); set_lim(1, 7);
    start_i = 2'b11; tick(); start_i = '0;
    en_i = 2'b11; repeat (5) tick();
    rst = 1'b1; tick(); rst = 1'b0; tick(); tick();

    // random traffic
    repeat (3000) begin
      rst     = ($urandom_range(299, 0) == 0);
      start_i = rbits(6);
      stop_i  = rbits(20);
      load_i  = rbits(16);
      clear_i = rbits(8);
      en_i    = ~rbits(4);
      cnt_i   = CW'($urandom);
      for (int k = 0; k < NUM_CH; k++) begin
        if ($urandom_range(19, 0) == 0) set_lim(k, int'($urandom_range(MOD - 1, 0)));
        if ($urandom_range(49, 0) == 0) sat_i[k] = ~sat_i[k];
        if ($urandom_range(49, 0) == 0) dir_i[k] = ~dir_i[k];
      end
      tick();
    end

    // drain and report
    rst = 1'b0; clr_strobes(); en_i = '0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
